// File: rtl/rti_unit_pkg.sv
// Shared ICU/RTI definitions: stack register ids,
// push/pop encoding, RTI state encoding and output decode.
package rti_unit_pkg;

  localparam logic [3:0] PCL_ID = 4'd8;
  localparam logic [3:0] PCH_ID = 4'd9;
  localparam logic [3:0] CCR_ID = 4'd10;

  localparam logic PUSH = 1'b1;
  localparam logic POP  = 1'b0;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_STALL_1   = 3'd1;
  localparam logic [2:0] S_POP_PCH   = 3'd2;
  localparam logic [2:0] S_POP_PCL   = 3'd3;
  localparam logic [2:0] S_POP_CCR   = 3'd4;
  localparam logic [2:0] S_PC_CHANGE = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = S_IDLE,
    STALL_1   = S_STALL_1,
    POP_PCH   = S_POP_PCH,
    POP_PCL   = S_POP_PCL,
    POP_CCR   = S_POP_CCR,
    PC_CHANGE = S_PC_CHANGE
  } rti_state_e;

  typedef struct packed {
    logic       drv;
    logic       stall;
    logic       stk;
    logic       branch;
    logic       id_drv;
    logic [3:0] id;
    logic       pc_drv;
    logic       ccr_wr;
    logic       done;
  } rti_out_t;

  // Output bundle presented while sitting in state s.
  function automatic rti_out_t rti_decode(
    input rti_state_e s
  );
    rti_out_t o;
    o = '0;
    unique case (s)
      STALL_1: begin
        o.drv   = 1'b1;
        o.stall = 1'b1;
      end
      POP_PCH: begin
        o.drv    = 1'b1;
        o.stk    = 1'b1;
        o.id_drv = 1'b1;
        o.id     = PCH_ID;
      end
      POP_PCL: begin
        o.drv    = 1'b1;
        o.stk    = 1'b1;
        o.id_drv = 1'b1;
        o.id     = PCL_ID;
      end
      POP_CCR: begin
        o.drv    = 1'b1;
        o.stk    = 1'b1;
        o.id_drv = 1'b1;
        o.id     = CCR_ID;
      end
      PC_CHANGE: begin
        o.drv    = 1'b1;
        o.branch = 1'b1;
        o.pc_drv = 1'b1;
        o.ccr_wr = 1'b1;
        o.done   = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/rti_unit.sv
// Return-from-interrupt sequencer: stall, pop PCH/PCL/CCR,
// restore CCR and branch; shared bus released while idle.
module rti_unit
  import rti_unit_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int PC_W     = 32,
  parameter int REG_ID_W = 4,
  parameter int CCR_W    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                rti_req,
  input  logic                pop_valid,
  input  logic [DATA_W-1:0]   pop_data,
  output logic                stall,
  output logic [REG_ID_W-1:0] reg_id,
  output logic                stack_operation,
  output logic                push_pop,
  output logic                branch,
  output logic [PC_W-1:0]     PC_VALUE,
  output logic                ccr_wr,
  output logic [CCR_W-1:0]    ccr_value,
  output logic                done
);

  rti_state_e        state;
  rti_state_e        nxt;
  rti_out_t          o_q;
  logic [DATA_W-1:0] pch_q;
  logic [DATA_W-1:0] pcl_q;
  logic [CCR_W-1:0]  ccr_q;

  // Next state; pop states wait for pop_valid.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      if (rti_req) nxt = STALL_1;
      STALL_1:   nxt = POP_PCH;
      POP_PCH:   if (pop_valid) nxt = POP_PCL;
      POP_PCL:   if (pop_valid) nxt = POP_CCR;
      POP_CCR:   if (pop_valid) nxt = PC_CHANGE;
      PC_CHANGE: nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // FSM, registered outputs and pop capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      o_q   <= '0;
      pch_q <= '0;
      pcl_q <= '0;
      ccr_q <= '0;
    end else if (enable) begin
      state <= nxt;
      o_q   <= rti_decode(nxt);
      if (pop_valid) begin
        if (state == POP_PCH) pch_q <= pop_data;
        if (state == POP_PCL) pcl_q <= pop_data;
        if (state == POP_CCR)
          ccr_q <= pop_data[CCR_W-1:0];
      end
    end
  end

  assign stall =
    o_q.drv ? o_q.stall : 1'bz;
  assign stack_operation =
    o_q.drv ? o_q.stk : 1'bz;
  assign push_pop =
    o_q.drv ? POP : 1'bz;
  assign branch =
    o_q.drv ? o_q.branch : 1'bz;
  assign reg_id =
    o_q.id_drv ? REG_ID_W'(o_q.id) : 'z;
  assign PC_VALUE =
    o_q.pc_drv ? PC_W'({pch_q, pcl_q}) : 'z;

  assign ccr_wr    = o_q.ccr_wr;
  assign done      = o_q.done;
  assign ccr_value = ccr_q;

endmodule

// File: tb/tb_rti_unit.sv
// Directed bench for rti_unit; two instances with pulled-down
// and pulled-up buses so released (z) outputs are observable.
module tb_rti_unit;

  localparam logic [63:0] ZV = '1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        rti_req = 1'b0;
  logic        pop_valid = 1'b0;
  logic [15:0] pop_data = '0;

  tri0        s0, k0, p0, b0;
  tri0 [3:0]  r0;
  tri0 [31:0] pc0;
  tri1        s1, k1, p1, b1;
  tri1 [3:0]  r1;
  tri1 [31:0] pc1;

  logic       ccr_wr, done, d_wr, d_done;
  logic [2:0] ccr_value, d_ccr;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rti_unit u0 (
    .clk(clk), .reset(reset), .enable(enable),
    .rti_req(rti_req), .pop_valid(pop_valid),
    .pop_data(pop_data), .stall(s0), .reg_id(r0),
    .stack_operation(k0), .push_pop(p0),
    .branch(b0), .PC_VALUE(pc0), .ccr_wr(ccr_wr),
    .ccr_value(ccr_value), .done(done)
  );

  rti_unit u1 (
    .clk(clk), .reset(reset), .enable(enable),
    .rti_req(rti_req), .pop_valid(pop_valid),
    .pop_data(pop_data), .stall(s1), .reg_id(r1),
    .stack_operation(k1), .push_pop(p1),
    .branch(b1), .PC_VALUE(pc1), .ccr_wr(d_wr),
    .ccr_value(d_ccr), .done(d_done)
  );

  function automatic logic [63:0] enc(
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    return (lo != hi) ? ZV : {32'b0, lo};
  endfunction

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ph: 0 idle,1 stall,2 pch,3 pcl,4 ccr,5 pc_change
  task automatic expect_ph(
    input string       t,
    input int          ph,
    input logic [31:0] pc,
    input logic [2:0]  ccr
  );
    logic [63:0] es, ek, ep, eb, er, epc;
    es = ZV; ek = ZV; ep = ZV;
    eb = ZV; er = ZV; epc = ZV;
    if (ph != 0) begin
      es = 0; ek = 0; ep = 0; eb = 0;
    end
    if (ph == 1) es = 1;
    if (ph >= 2 && ph <= 4) ek = 1;
    if (ph == 2) er = 9;
    if (ph == 3) er = 8;
    if (ph == 4) er = 10;
    if (ph == 5) begin
      eb = 1;
      epc = {32'b0, pc};
    end
    check({t, ".stall"}, enc(32'(s0), 32'(s1)), es);
    check({t, ".stk"}, enc(32'(k0), 32'(k1)), ek);
    check({t, ".pp"}, enc(32'(p0), 32'(p1)), ep);
    check({t, ".br"}, enc(32'(b0), 32'(b1)), eb);
    check({t, ".id"}, enc(32'(r0), 32'(r1)), er);
    check({t, ".pc"}, enc(pc0, pc1), epc);
    check({t, ".wr"}, 64'(ccr_wr), 64'(ph == 5));
    check({t, ".done"}, 64'(done), 64'(ph == 5));
    if (ph == 5)
      check({t, ".ccr"}, 64'(ccr_value), 64'(ccr));
  endtask

  task automatic full_seq(
    input string       t,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [15:0] c
  );
    rti_req = 1'b1;
    pop_valid = 1'b1;
    tick;
    rti_req = 1'b0;
    expect_ph({t, ".c2"}, 1, 0, 0);
    tick;
    expect_ph({t, ".c3"}, 2, 0, 0);
    pop_data = a;
    tick;
    expect_ph({t, ".c4"}, 3, 0, 0);
    pop_data = b;
    tick;
    expect_ph({t, ".c5"}, 4, 0, 0);
    pop_data = c;
    tick;
    expect_ph({t, ".c6"}, 5, {a, b}, c[2:0]);
    tick;
    expect_ph({t, ".c7"}, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    // T1 reset and idle
    #3;
    expect_ph("t1.rst", 0, 0, 0);
    check("t1.rccr", 64'(ccr_value), 64'd0);
    tick;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      expect_ph("t1.idle", 0, 0, 0);
    end

    // T2 basic sequence
    full_seq("t2", 16'h1234, 16'hABCD, 16'h0005);
    check("t2.ccr_hold", 64'(ccr_value), 64'd5);

    // T3 pop_valid gap in POP_PCL
    rti_req = 1'b1;
    pop_valid = 1'b1;
    tick;
    rti_req = 1'b0;
    expect_ph("t3.stall", 1, 0, 0);
    tick;
    expect_ph("t3.pch", 2, 0, 0);
    pop_data = 16'h0BAD;
    tick;
    expect_ph("t3.pcl0", 3, 0, 0);
    pop_valid = 1'b0;
    pop_data = 16'hFFFF;
    tick;
    expect_ph("t3.pcl1", 3, 0, 0);
    tick;
    expect_ph("t3.pcl2", 3, 0, 0);
    pop_valid = 1'b1;
    pop_data = 16'hF00D;
    tick;
    expect_ph("t3.ccr", 4, 0, 0);
    pop_data = 16'h0012;
    tick;
    expect_ph("t3.chg", 5, 32'h0BADF00D, 3'd2);
    tick;
    expect_ph("t3.end", 0, 0, 0);

    // T4 enable low in POP_PCH
    rti_req = 1'b1;
    tick;
    rti_req = 1'b0;
    tick;
    expect_ph("t4.pch", 2, 0, 0);
    enable = 1'b0;
    pop_data = 16'h5555;
    tick;
    expect_ph("t4.hold1", 2, 0, 0);
    tick;
    expect_ph("t4.hold2", 2, 0, 0);
    enable = 1'b1;
    pop_data = 16'h1357;
    tick;
    expect_ph("t4.pcl", 3, 0, 0);
    pop_data = 16'h2468;
    tick;
    expect_ph("t4.ccr", 4, 0, 0);
    pop_data = 16'h0007;
    tick;
    expect_ph("t4.chg", 5, 32'h13572468, 3'd7);
    tick;
    expect_ph("t4.end", 0, 0, 0);

    // T5 reset in POP_CCR
    rti_req = 1'b1;
    tick;
    rti_req = 1'b0;
    pop_data = 16'h4444;
    tick;
    tick;
    tick;
    expect_ph("t5.ccr", 4, 0, 0);
    reset = 1'b0;
    #1;
    expect_ph("t5.abort", 0, 0, 0);
    check("t5.rccr", 64'(ccr_value), 64'd0);
    tick;
    reset = 1'b1;
    tick;
    expect_ph("t5.after", 0, 0, 0);
    full_seq("t5.re", 16'hCAFE, 16'hBEEF, 16'h0003);

    // T6 rti_req held high
    rti_req = 1'b1;
    pop_valid = 1'b1;
    pop_data = 16'h00C3;
    tick;
    expect_ph("t6.s", 1, 0, 0);
    tick;
    expect_ph("t6.a", 2, 0, 0);
    tick;
    expect_ph("t6.b", 3, 0, 0);
    tick;
    expect_ph("t6.c", 4, 0, 0);
    tick;
    expect_ph("t6.chg", 5, 32'h00C300C3, 3'd3);
    tick;
    expect_ph("t6.idle", 0, 0, 0);
    tick;
    expect_ph("t6.s2", 1, 0, 0);
    rti_req = 1'b0;
    tick;
    tick;
    tick;
    tick;
    expect_ph("t6.chg2", 5, 32'h00C300C3, 3'd3);
    tick;
    expect_ph("t6.end", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
